// File: rtl/costas_pkg.sv
// costas_pkg: shared types and widths for the Costas loop and its acquisition sequencer.
package costas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_PULLIN,
        ST_TRACK,
        ST_FAIL
    } state_e;

    localparam int MET_W    = 17;
    localparam int METRIC_W = 32;

    localparam logic [3:0] GAIN_ACQ_DEF = 4'd4;
    localparam logic [3:0] GAIN_TRK_DEF = 4'd8;

    function automatic int acc_w(input int win_log2);
        return MET_W + win_log2;
    endfunction

endpackage

// File: rtl/costas_acq_ctrl_if.sv
// costas_acq_ctrl_if: control, filtered I/Q input and loop-control output bundle of the sequencer.
interface costas_acq_ctrl_if;
    import costas_pkg::*;

    logic               start;
    logic               abort;
    logic signed [15:0] i_filt;
    logic signed [15:0] q_filt;
    logic               filt_valid;
    logic [31:0]        phase_inc;
    logic [3:0]         loop_shift;
    logic               loop_en;
    logic               loop_clr;
    logic               locked;
    logic               fail;
    state_e             state;

    modport slave (
        input  start, abort, i_filt, q_filt, filt_valid,
        output phase_inc, loop_shift, loop_en, loop_clr, locked, fail, state
    );

    modport master (
        output start, abort, i_filt, q_filt, filt_valid,
        input  phase_inc, loop_shift, loop_en, loop_clr, locked, fail, state
    );

endinterface

// File: rtl/costas_lock_metric.sv
// costas_lock_metric: windowed sum of |i|-|q| over 2^WIN_LOG2 valid samples.
// win_done_o and metric_o include the sample of the current cycle so the FSM decides on that edge.
module costas_lock_metric import costas_pkg::*; #(
    parameter int WIN_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic                       valid_i,
    input  logic signed [15:0]         i_i,
    input  logic signed [15:0]         q_i,
    output logic                       win_done_o,
    output logic signed [METRIC_W-1:0] metric_o
);
    localparam int AW = acc_w(WIN_LOG2);

    logic [WIN_LOG2-1:0] cnt_q;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [MET_W-1:0] m;

    function automatic logic signed [MET_W-1:0] abs_sat(input logic signed [15:0] x);
        return (x == 16'sh8000) ? 17'sd32767 : (x[15] ? -MET_W'(x) : MET_W'(x));
    endfunction

    assign m          = abs_sat(i_i) - abs_sat(q_i);
    assign acc_d      = acc_q + AW'(m);
    assign win_done_o = en_i && valid_i && (&cnt_q);
    assign metric_o   = METRIC_W'(acc_d);

    // Leaving the measuring states or closing a window restarts the next window from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (!en_i || win_done_o) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (valid_i) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/costas_acq_ctrl.sv
// costas_acq_ctrl: frequency-sweep acquisition and lock sequencer for the 2PSK Costas loop.
// Sweeps phase_inc, settles, scores lock windows, and switches acquisition/tracking gain.
module costas_acq_ctrl import costas_pkg::*; #(
    parameter logic [31:0]        F_CENTER   = 32'd171_798_692,
    parameter logic [31:0]        F_STEP     = 32'd429_497,
    parameter int                 SPAN       = 16,
    parameter int                 SETTLE_CYC = 4096,
    parameter int                 WIN_LOG2   = 8,
    parameter logic signed [31:0] LOCK_THR   = 32'sd200_000,
    parameter logic signed [31:0] UNLOCK_THR = 32'sd80_000,
    parameter int                 CONFIRM    = 3,
    parameter int                 LOSS_CNT   = 4,
    parameter int                 MAX_SWEEPS = 3,
    parameter logic [3:0]         GAIN_ACQ   = GAIN_ACQ_DEF,
    parameter logic [3:0]         GAIN_TRK   = GAIN_TRK_DEF
) (
    input logic               clk,
    input logic               rst_n,
    costas_acq_ctrl_if.slave  bus
);
    localparam logic [31:0] F_START = F_CENTER - 32'(SPAN) * F_STEP;
    localparam int IW = $clog2(2 * SPAN + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int KW = $clog2(MAX_SWEEPS + 1);
    localparam int CW = $clog2(CONFIRM + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(2 * SPAN);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [KW-1:0] SWEEP_LAST  = KW'(MAX_SWEEPS - 1);
    localparam logic [CW-1:0] CONF_LAST   = CW'(CONFIRM - 1);
    localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_CNT - 1);

    state_e        state_q;
    logic [31:0]   phase_q, phase_d;
    logic [3:0]    shift_q;
    logic          en_q, clr_q, locked_q, fail_q;
    logic [IW-1:0] idx_q, idx_d;
    logic [KW-1:0] sweeps_q, sweeps_d;
    logic [SW-1:0] settle_q;
    logic [CW-1:0] confirm_q;
    logic [LW-1:0] loss_q;
    logic          measuring, win_done, pass, hold, last_pt, exhausted;
    logic signed [METRIC_W-1:0] metric;

    assign measuring = state_q == ST_MEASURE || state_q == ST_PULLIN || state_q == ST_TRACK;

    costas_lock_metric #(.WIN_LOG2(WIN_LOG2)) u_metric (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (measuring),
        .valid_i    (bus.filt_valid),
        .i_i        (bus.i_filt),
        .q_i        (bus.q_filt),
        .win_done_o (win_done),
        .metric_o   (metric)
    );

    assign pass      = metric >= LOCK_THR;
    assign hold      = metric >= UNLOCK_THR;
    assign last_pt   = idx_q == IDX_LAST;
    assign exhausted = last_pt && sweeps_q == SWEEP_LAST;
    assign idx_d     = last_pt ? '0 : idx_q + 1'b1;
    assign sweeps_d  = last_pt ? sweeps_q + 1'b1 : sweeps_q;
    assign phase_d   = last_pt ? F_START : phase_q + F_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= F_CENTER;
            shift_q   <= GAIN_ACQ;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
            idx_q     <= '0;
            sweeps_q  <= '0;
            settle_q  <= '0;
            confirm_q <= '0;
            loss_q    <= '0;
        end else begin
            clr_q <= 1'b0;
            if (bus.abort) begin
                state_q   <= ST_IDLE;
                shift_q   <= GAIN_ACQ;
                en_q      <= 1'b0;
                locked_q  <= 1'b0;
                fail_q    <= 1'b0;
                idx_q     <= '0;
                sweeps_q  <= '0;
                settle_q  <= '0;
                confirm_q <= '0;
                loss_q    <= '0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_FAIL: if (bus.start) begin
                        state_q  <= ST_SETTLE;
                        clr_q    <= 1'b1;
                        en_q     <= 1'b1;
                        fail_q   <= 1'b0;
                        phase_q  <= F_START;
                        idx_q    <= '0;
                        sweeps_q <= '0;
                        settle_q <= '0;
                    end
                    ST_SETTLE: begin
                        settle_q <= settle_q + 1'b1;
                        if (settle_q == SETTLE_LAST) state_q <= ST_MEASURE;
                    end
                    // A failing window in MEASURE or PULLIN moves to the next sweep point.
                    ST_MEASURE, ST_PULLIN: if (win_done) begin
                        if (pass) begin
                            confirm_q <= state_q == ST_MEASURE ? CW'(1) : confirm_q + 1'b1;
                            if (state_q == ST_PULLIN && confirm_q == CONF_LAST) begin
                                state_q  <= ST_TRACK;
                                locked_q <= 1'b1;
                                shift_q  <= GAIN_TRK;
                                loss_q   <= '0;
                            end else begin
                                state_q <= ST_PULLIN;
                            end
                        end else begin
                            idx_q    <= idx_d;
                            sweeps_q <= sweeps_d;
                            settle_q <= '0;
                            if (exhausted) begin
                                state_q <= ST_FAIL;
                                fail_q  <= 1'b1;
                                en_q    <= 1'b0;
                            end else begin
                                state_q <= ST_SETTLE;
                                phase_q <= phase_d;
                                clr_q   <= 1'b1;
                            end
                        end
                    end
                    ST_TRACK: if (win_done) begin
                        if (hold) begin
                            loss_q <= '0;
                        end else if (loss_q == LOSS_LAST) begin
                            state_q  <= ST_SETTLE;
                            locked_q <= 1'b0;
                            shift_q  <= GAIN_ACQ;
                            clr_q    <= 1'b1;
                            sweeps_q <= '0;
                            settle_q <= '0;
                            loss_q   <= '0;
                        end else begin
                            loss_q <= loss_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.phase_inc  = phase_q;
    assign bus.loop_shift = shift_q;
    assign bus.loop_en    = en_q;
    assign bus.loop_clr   = clr_q;
    assign bus.locked     = locked_q;
    assign bus.fail       = fail_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// tb_costas_acq_ctrl: directed bench for the acquisition sequencer with small sweep/window parameters.
module tb_costas_acq_ctrl;
    import costas_pkg::*;

    localparam int SETTLE_CYC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   clr_cnt = 0;
    int   clr_base;

    costas_acq_ctrl_if bus();

    costas_acq_ctrl #(
        .F_CENTER   (32'd1000),
        .F_STEP     (32'd10),
        .SPAN       (2),
        .SETTLE_CYC (SETTLE_CYC),
        .WIN_LOG2   (2),
        .LOCK_THR   (32'sd1000),
        .UNLOCK_THR (32'sd400),
        .CONFIRM    (2),
        .LOSS_CNT   (2),
        .MAX_SWEEPS (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.loop_clr) clr_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic window(input logic signed [15:0] i, input logic signed [15:0] q);
        bus.filt_valid = 1'b1;
        bus.i_filt = i;
        bus.q_filt = q;
        repeat (4) step();
        bus.filt_valid = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_phase"}, bus.phase_inc, 1000);
        chk({tag, "_shift"}, 32'(bus.loop_shift), 4);
        chk({tag, "_en"}, 32'(bus.loop_en), 0);
        chk({tag, "_clr"}, 32'(bus.loop_clr), 0);
        chk({tag, "_locked"}, 32'(bus.locked), 0);
        chk({tag, "_fail"}, 32'(bus.fail), 0);
        chk({tag, "_state"}, 32'(bus.state), ST_IDLE);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.i_filt = '0;
        bus.q_filt = '0;
        bus.filt_valid = 1'b0;
        repeat (3) step();
        reset_vals("rst");
        rst_n = 1'b1;
        step();

        // full sweep with no signal ends in FAIL
        clr_base = clr_cnt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int p = 0; p < 5; p++) begin
            chk("sw_state", 32'(bus.state), ST_SETTLE);
            chk("sw_clr", 32'(bus.loop_clr), 1);
            chk("sw_en", 32'(bus.loop_en), 1);
            chk("sw_phase", bus.phase_inc, 32'(980 + 10 * p));
            step();
            chk("sw_clr_low", 32'(bus.loop_clr), 0);
            repeat (SETTLE_CYC - 2) step();
            chk("sw_still_settle", 32'(bus.state), ST_SETTLE);
            step();
            chk("sw_measure", 32'(bus.state), ST_MEASURE);
            window(16'sd0, 16'sd0);
        end
        chk("sw_fail_state", 32'(bus.state), ST_FAIL);
        chk("sw_fail", 32'(bus.fail), 1);
        chk("sw_fail_en", 32'(bus.loop_en), 0);
        chk("sw_fail_phase", bus.phase_inc, 1020);
        chk("sw_clr_pulses", 32'(clr_cnt - clr_base), 5);

        // restart from FAIL and pull in at the first point
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("acq_state", 32'(bus.state), ST_SETTLE);
        chk("acq_fail_clr", 32'(bus.fail), 0);
        chk("acq_phase", bus.phase_inc, 980);
        repeat (SETTLE_CYC) step();
        chk("acq_measure", 32'(bus.state), ST_MEASURE);
        window(16'sd500, 16'sd0);
        chk("acq_pullin", 32'(bus.state), ST_PULLIN);
        chk("acq_pullin_lock", 32'(bus.locked), 0);
        window(16'sd500, 16'sd0);
        chk("acq_track", 32'(bus.state), ST_TRACK);
        chk("acq_locked", 32'(bus.locked), 1);
        chk("acq_shift", 32'(bus.loop_shift), 8);
        chk("acq_phase_trk", bus.phase_inc, 980);

        // saturating |-32768| keeps lock
        bus.filt_valid = 1'b1;
        bus.i_filt = 16'sh8000;
        bus.q_filt = 16'sd0;
        repeat (3) step();
        chk("sat_metric", dut.metric, 131068);
        step();
        bus.filt_valid = 1'b0;
        chk("sat_track", 32'(bus.state), ST_TRACK);
        chk("sat_locked", 32'(bus.locked), 1);

        // a pass between two weak windows clears the loss count
        window(16'sd50, 16'sd0);
        chk("hy_weak1", 32'(bus.locked), 1);
        window(16'sd500, 16'sd0);
        chk("hy_pass", 32'(bus.locked), 1);
        window(16'sd50, 16'sd0);
        chk("hy_weak_again", 32'(bus.locked), 1);
        chk("hy_weak_state", 32'(bus.state), ST_TRACK);

        // second consecutive weak window drops lock
        window(16'sd50, 16'sd0);
        chk("loss_locked", 32'(bus.locked), 0);
        chk("loss_state", 32'(bus.state), ST_SETTLE);
        chk("loss_phase", bus.phase_inc, 980);
        chk("loss_shift", 32'(bus.loop_shift), 4);
        chk("loss_clr", 32'(bus.loop_clr), 1);

        // abort mid-SETTLE, then abort together with start
        repeat (3) step();
        clr_base = clr_cnt;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("ab_state", 32'(bus.state), ST_IDLE);
        chk("ab_en", 32'(bus.loop_en), 0);
        chk("ab_clr", 32'(bus.loop_clr), 0);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abst_state", 32'(bus.state), ST_IDLE);
        chk("abst_en", 32'(bus.loop_en), 0);
        step();
        chk("abst_no_clr", 32'(clr_cnt - clr_base), 0);

        // asynchronous reset in PULLIN
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (SETTLE_CYC) step();
        window(16'sd500, 16'sd0);
        chk("ar_pullin", 32'(bus.state), ST_PULLIN);
        #2;
        rst_n = 1'b0;
        #1;
        reset_vals("ar");
        step();
        rst_n = 1'b1;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ar_restart_state", 32'(bus.state), ST_SETTLE);
        chk("ar_restart_phase", bus.phase_inc, 980);
        chk("ar_restart_clr", 32'(bus.loop_clr), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
